// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//
// Groups every signal of the receive FIFO except clk/rst.
//
// Receiver side:
//   dataOut[8:0]   character held by the receiver
//   dataReceived   the receiver's holding register is valid (level)
//   parityError    parity error on the held character
//   breakCond      the held character is a break condition.
//                  The receiver calls this "break", which is a reserved word.
//   overflow       the receiver lost a character (level)
//   receiveData    one-cycle acknowledge pulse back to the receiver
//
// Host side:
//   rdData[10:0]   head entry {breakCond, parityError, data}; 0 when empty
//   rdValid        the FIFO is not empty
//   rdEn           pop the head entry
//   count          occupancy, from 0 to 2^DEPTH_LOG2
//   full           occupancy equals the depth
//   rxOverflow     sticky receiver-overflow flag
//   fifoStall      sticky flag: a character waited while the FIFO was full
//   clearStatus    clears both sticky flags
//
// Modports:
//   master         the environment, which is the receiver plus the host
//   slave          the FIFO
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [8:0]          dataOut;
    logic                dataReceived;
    logic                parityError;
    logic                breakCond;
    logic                overflow;
    logic                receiveData;
    logic [10:0]         rdData;
    logic                rdValid;
    logic                rdEn;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                rxOverflow;
    logic                fifoStall;
    logic                clearStatus;

    modport master (
        output dataOut, dataReceived, parityError, breakCond, overflow,
               rdEn, clearStatus,
        input  receiveData, rdData, rdValid, count, full, rxOverflow, fifoStall
    );

    modport slave (
        input  dataOut, dataReceived, parityError, breakCond, overflow,
               rdEn, clearStatus,
        output receiveData, rdData, rdValid, count, full, rxOverflow, fifoStall
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer that sits directly after UartReceiver. Each completed
// character is taken from the receiver's holding register. The FIFO pulses
// receiveData to acknowledge it, and stores the character with its error
// flags in a circular buffer. The host reads the buffer through a
// show-ahead port. Sticky flags record receiver overflow and FIFO-full
// back-pressure.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   uart_rx_fifo_if.slave. It carries the receiver handshake, the host
//         read port and the status flags.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [10:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   occupancy;
    logic                  ack_q;
    logic                  overflow_q;
    logic                  stall_q;
    logic                  capture;
    logic                  stall_seen;
    logic                  pop;
    logic                  is_full;
    logic                  is_empty;

    assign is_full  = (occupancy == FULL_COUNT);
    assign is_empty = (occupancy == '0);
    assign pop      = bus.rdEn && !is_empty;

    // Capture decision and next state.
    // A character is taken only from IDLE. The FSM then passes through ACK,
    // where receiveData is high. It waits in WAIT until the receiver has
    // dropped dataReceived, so one held character is never captured twice.
    // The full test uses the occupancy at the start of the cycle. A pop in
    // the same cycle therefore does not make room for a capture until the
    // next cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        stall_seen = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dataReceived) begin
                    if (!is_full) begin
                        capture    = 1'b1;
                        state_next = S_ACK;
                    end else begin
                        stall_seen = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.dataReceived) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register and registered acknowledge.
    // receiveData is high only in the cycle after a capture. The reset is
    // asynchronous, so it drops at once if reset arrives mid-handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= capture;
        end
    end

    // Storage array.
    // It is not reset. Whatever it holds after reset is unreachable,
    // because the pointers and the occupancy restart at zero.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= {bus.breakCond, bus.parityError, bus.dataOut};
        end
    end

    // Pointers and occupancy.
    // The pointers wrap at the depth without extra logic. The occupancy is
    // kept as its own counter, which gives full and empty directly.
    // A capture and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Sticky status flags.
    // If a flag's set condition is true in the same cycle as clearStatus,
    // the set wins. A condition that is still present cannot be hidden by
    // a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            if (bus.overflow) begin
                overflow_q <= 1'b1;
            end else if (bus.clearStatus) begin
                overflow_q <= 1'b0;
            end
            if (stall_seen) begin
                stall_q <= 1'b1;
            end else if (bus.clearStatus) begin
                stall_q <= 1'b0;
            end
        end
    end

    assign bus.receiveData = ack_q;
    assign bus.rdData      = is_empty ? 11'd0 : mem[rd_ptr];
    assign bus.rdValid     = !is_empty;
    assign bus.count       = occupancy;
    assign bus.full        = is_full;
    assign bus.rxOverflow  = overflow_q;
    assign bus.fifoStall   = stall_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with the default depth of 16.
// The receiver handshake and the host reads are driven from the bench.
// Expected values are worked out by hand. For the long run with pointer
// wrap, a small queue supplies them.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ack_pulses = 0;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Count every acknowledge pulse the FIFO sends to the receiver.
    always @(posedge bus.receiveData) ack_pulses++;

    // Watchdog.
    // The bench stops even if the design hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with the expected one, and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Act as the receiver for one character.
    // Hold it until the acknowledge is seen, then release it. Wait long
    // enough for the FIFO to return to IDLE before the next character.
    task automatic applyStimulus(input logic [8:0] d, input logic pe, input logic brk);
        bit seen = 1'b0;
        @(negedge clk);
        bus.dataOut      = d;
        bus.parityError  = pe;
        bus.breakCond    = brk;
        bus.dataReceived = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.receiveData === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
        bus.dataReceived = 1'b0;
        bus.parityError  = 1'b0;
        bus.breakCond    = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Host read.
    // Sample the head entry, then pop it with a one-cycle rdEn.
    task automatic popEntry(output logic [10:0] head);
        @(negedge clk);
        head     = bus.rdData;
        bus.rdEn = 1'b1;
        @(negedge clk);
        bus.rdEn = 1'b0;
    endtask

    // Wait a bounded number of cycles for an acknowledge.
    task automatic waitAck(input string tag, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.receiveData === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [10:0] head;
        logic [8:0]  model_q [$];
        int          snap;

        bus.dataOut      = '0;
        bus.dataReceived = 1'b0;
        bus.parityError  = 1'b0;
        bus.breakCond    = 1'b0;
        bus.overflow     = 1'b0;
        bus.rdEn         = 1'b0;
        bus.clearStatus  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_receiveData", 32'(bus.receiveData), 32'd0);
        checkOutput("rst_rdValid",     32'(bus.rdValid),     32'd0);
        checkOutput("rst_count",       32'(bus.count),       32'd0);
        checkOutput("rst_full",        32'(bus.full),        32'd0);
        checkOutput("rst_rdData",      32'(bus.rdData),      32'd0);
        checkOutput("rst_status",      32'({bus.rxOverflow, bus.fifoStall}), 32'd0);
        rst = 1'b0;

        // Single character 0x60
        snap = ack_pulses;
        applyStimulus(9'h060, 1'b0, 1'b0);
        checkOutput("single_acks",   32'(ack_pulses - snap), 32'd1);
        checkOutput("single_count",  32'(bus.count),         32'd1);
        checkOutput("single_rdData", 32'(bus.rdData),        32'h060);
        popEntry(head);
        checkOutput("single_after_count",  32'(bus.count),  32'd0);
        checkOutput("single_after_rdData", 32'(bus.rdData), 32'd0);

        // Error flags are stored with the data
        applyStimulus(9'h1A5, 1'b1, 1'b0);
        applyStimulus(9'h000, 1'b0, 1'b1);
        popEntry(head);
        checkOutput("parity_entry", 32'(head), 32'h3A5);
        popEntry(head);
        checkOutput("break_entry", 32'(head), 32'h400);

        // Fill to full, then a stalled 17th character
        for (int i = 0; i < 16; i++) applyStimulus(9'(i), 1'b0, 1'b0);
        checkOutput("fill_full",  32'(bus.full),  32'd1);
        checkOutput("fill_count", 32'(bus.count), 32'd16);
        @(negedge clk);
        bus.dataOut      = 9'h010;
        bus.dataReceived = 1'b1;
        snap = ack_pulses;
        repeat (5) @(negedge clk);
        checkOutput("stall_no_ack", 32'(ack_pulses - snap), 32'd0);
        checkOutput("stall_flag",   32'(bus.fifoStall),     32'd1);
        checkOutput("stall_count",  32'(bus.count),         32'd16);
        popEntry(head);
        checkOutput("stall_pop_head", 32'(head), 32'h000);
        waitAck("stall_capture", 2);
        bus.dataReceived = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("refill_count",  32'(bus.count),  32'd16);
        checkOutput("refill_rdData", 32'(bus.rdData), 32'h001);
        @(negedge clk);
        bus.clearStatus = 1'b1;
        @(negedge clk);
        bus.clearStatus = 1'b0;
        checkOutput("stall_cleared", 32'(bus.fifoStall), 32'd0);
        for (int i = 0; i < 16; i++) begin
            popEntry(head);
            checkOutput("drain_full", 32'(head), 32'(i + 1));
        end
        checkOutput("drain_empty", 32'(bus.rdValid), 32'd0);

        // Capture and pop in the same cycle at count 5
        for (int i = 0; i < 5; i++) applyStimulus(9'(32 + i), 1'b0, 1'b0);
        @(negedge clk);
        bus.dataOut      = 9'h025;
        bus.dataReceived = 1'b1;
        bus.rdEn         = 1'b1;
        @(negedge clk);
        bus.rdEn = 1'b0;
        checkOutput("simul_count", 32'(bus.count),       32'd5);
        checkOutput("simul_ack",   32'(bus.receiveData), 32'd1);
        bus.dataReceived = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            popEntry(head);
            checkOutput("simul_order", 32'(head), 32'(33 + i));
        end

        // 40 characters with periodic reads, wrapping the pointers
        for (int i = 0; i < 40; i++) begin
            applyStimulus(9'((i * 7 + 3) % 512), 1'b0, 1'b0);
            model_q.push_back(9'((i * 7 + 3) % 512));
            if (i % 3 == 2) begin
                for (int k = 0; k < 2; k++) begin
                    popEntry(head);
                    checkOutput("wrap_order", 32'(head), 32'(model_q.pop_front()));
                end
            end
        end
        checkOutput("wrap_count", 32'(bus.count), 32'(model_q.size()));
        while (model_q.size() > 0) begin
            popEntry(head);
            checkOutput("wrap_drain", 32'(head), 32'(model_q.pop_front()));
        end

        // Sticky overflow flag: clearing loses to a set in the same cycle
        @(negedge clk);
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ovf_sticky", 32'(bus.rxOverflow), 32'd1);
        bus.overflow    = 1'b1;
        bus.clearStatus = 1'b1;
        @(negedge clk);
        checkOutput("ovf_set_wins", 32'(bus.rxOverflow), 32'd1);
        bus.overflow = 1'b0;
        @(negedge clk);
        bus.clearStatus = 1'b0;
        checkOutput("ovf_cleared", 32'(bus.rxOverflow), 32'd0);

        // Reset during WAIT with three entries stored
        applyStimulus(9'h031, 1'b0, 1'b0);
        applyStimulus(9'h032, 1'b0, 1'b0);
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.overflow     = 1'b0;
        bus.dataOut      = 9'h077;
        bus.dataReceived = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wait_count", 32'(bus.count), 32'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_count",   32'(bus.count),   32'd0);
        checkOutput("arst_rdValid", 32'(bus.rdValid), 32'd0);
        checkOutput("arst_rdData",  32'(bus.rdData),  32'd0);
        checkOutput("arst_ack",     32'(bus.receiveData), 32'd0);
        checkOutput("arst_status",  32'({bus.rxOverflow, bus.fifoStall}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        waitAck("post_rst_capture", 3);
        checkOutput("post_rst_count",  32'(bus.count),  32'd1);
        checkOutput("post_rst_rdData", 32'(bus.rdData), 32'h077);
        bus.dataReceived = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // A pop on an empty FIFO is ignored
        popEntry(head);
        checkOutput("last_head", 32'(head), 32'h077);
        popEntry(head);
        checkOutput("empty_pop_count", 32'(bus.count),   32'd0);
        checkOutput("empty_pop_valid", 32'(bus.rdValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
